// File: rtl/pic_decode_pipe_pkg.sv
// Decode constants shared by the PIC10F20x decode pipe, its opcode classifier
// and the disassembler monitor.
package pic_decode_pipe_pkg;

  localparam int unsigned INST_DEC_WIDTH = 6;
  localparam int unsigned ALU_INST_WIDTH = INST_DEC_WIDTH;

  typedef enum logic [INST_DEC_WIDTH-1:0] {
    OP_NOP, OP_ADDWF, OP_ANDWF, OP_CLRF, OP_CLRW, OP_COMF, OP_DECF, OP_DECFSZ,
    OP_INCF, OP_INCFSZ, OP_IORWF, OP_MOVF, OP_MOVWF, OP_RLF, OP_RRF, OP_SUBWF,
    OP_SWAPF, OP_XORWF, OP_BCF, OP_BSF, OP_BTFSC, OP_BTFSS, OP_ANDLW, OP_CALL,
    OP_CLRWDT, OP_GOTO, OP_IORLW, OP_MOVLW, OP_OPTION, OP_RETLW, OP_SLEEP,
    OP_TRIS, OP_XORLW
  } alu_op_e;

  // Illegal words reach the ALU as a harmless NOP; the illegal flag tells them apart.
  localparam alu_op_e ILLEGAL = OP_NOP;

  typedef enum logic {
    DEC_RUN    = 1'b0,
    DEC_SQUASH = 1'b1
  } dec_state_e;

endpackage

// File: rtl/pic_decode_pipe_if.sv
// Fetch-side handshake plus the registered ALU/branch bundle of the decode pipe.
interface pic_decode_pipe_if
  import pic_decode_pipe_pkg::*;
#(
  parameter int unsigned PIC_INSTR_WIDTH = 12,
  parameter int unsigned PC_WIDTH        = 9,
  parameter int unsigned L2_NUM_FREG     = 5,
  parameter int unsigned DWIDTH          = 8,
  parameter int unsigned ILL_CNT_WIDTH   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [PIC_INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]        in_pc;
  logic                       flush;
  logic                       out_ready;
  logic                       out_valid;
  logic [ALU_INST_WIDTH-1:0]  alu_instruction;
  logic [L2_NUM_FREG-1:0]     alu_freg_num;
  logic [2:0]                 alu_bit_num;
  logic                       alu_dest_bit;
  logic [DWIDTH-1:0]          alu_literal_value;
  logic                       branch_en;
  logic [PC_WIDTH-1:0]        branch_addr;
  logic                       push_en;
  logic [PC_WIDTH-1:0]        push_addr;
  logic                       pop_en;
  logic                       illegal;
  logic [ILL_CNT_WIDTH-1:0]   ill_count;

  modport slave (
    input  in_valid, instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, alu_instruction, alu_freg_num, alu_bit_num,
           alu_dest_bit, alu_literal_value, branch_en, branch_addr, push_en,
           push_addr, pop_en, illegal, ill_count
  );

  modport master (
    output in_valid, instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, alu_instruction, alu_freg_num, alu_bit_num,
           alu_dest_bit, alu_literal_value, branch_en, branch_addr, push_en,
           push_addr, pop_en, illegal, ill_count
  );

endinterface

// File: rtl/pic_decode_pipe_opcode_match.sv
// Purely combinational PIC10F20x baseline opcode classifier; anything not in
// the table comes out as an illegal NOP.
module pic_decode_pipe_opcode_match
  import pic_decode_pipe_pkg::*;
(
  input  logic [11:0] instr_i,
  output alu_op_e     op_c_o,
  output logic        is_branch_c_o,
  output logic        is_call_c_o,
  output logic        is_ret_c_o,
  output logic        is_illegal_c_o
);

  always_comb begin
    op_c_o         = ILLEGAL;
    is_branch_c_o  = 1'b0;
    is_call_c_o    = 1'b0;
    is_ret_c_o     = 1'b0;
    is_illegal_c_o = 1'b0;
    casez (instr_i)
      12'b0000_0000_0000: op_c_o = OP_NOP;
      12'b0000_0000_0010: op_c_o = OP_OPTION;
      12'b0000_0000_0011: op_c_o = OP_SLEEP;
      12'b0000_0000_0100: op_c_o = OP_CLRWDT;
      12'b0000_0000_0110: op_c_o = OP_TRIS;
      12'b0000_001?_????: op_c_o = OP_MOVWF;
      12'b0000_0100_0000: op_c_o = OP_CLRW;
      12'b0000_011?_????: op_c_o = OP_CLRF;
      12'b0000_10??_????: op_c_o = OP_SUBWF;
      12'b0000_11??_????: op_c_o = OP_DECF;
      12'b0001_00??_????: op_c_o = OP_IORWF;
      12'b0001_01??_????: op_c_o = OP_ANDWF;
      12'b0001_10??_????: op_c_o = OP_XORWF;
      12'b0001_11??_????: op_c_o = OP_ADDWF;
      12'b0010_00??_????: op_c_o = OP_MOVF;
      12'b0010_01??_????: op_c_o = OP_COMF;
      12'b0010_10??_????: op_c_o = OP_INCF;
      12'b0010_11??_????: op_c_o = OP_DECFSZ;
      12'b0011_00??_????: op_c_o = OP_RRF;
      12'b0011_01??_????: op_c_o = OP_RLF;
      12'b0011_10??_????: op_c_o = OP_SWAPF;
      12'b0011_11??_????: op_c_o = OP_INCFSZ;
      12'b0100_????_????: op_c_o = OP_BCF;
      12'b0101_????_????: op_c_o = OP_BSF;
      12'b0110_????_????: op_c_o = OP_BTFSC;
      12'b0111_????_????: op_c_o = OP_BTFSS;
      12'b1000_????_????: begin
        op_c_o        = OP_RETLW;
        is_branch_c_o = 1'b1;
        is_ret_c_o    = 1'b1;
      end
      12'b1001_????_????: begin
        op_c_o        = OP_CALL;
        is_branch_c_o = 1'b1;
        is_call_c_o   = 1'b1;
      end
      12'b101?_????_????: begin
        op_c_o        = OP_GOTO;
        is_branch_c_o = 1'b1;
      end
      12'b1100_????_????: op_c_o = OP_MOVLW;
      12'b1101_????_????: op_c_o = OP_IORLW;
      12'b1110_????_????: op_c_o = OP_ANDLW;
      12'b1111_????_????: op_c_o = OP_XORLW;
      default:            is_illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pic_decode_pipe.sv
// Single-entry registered decode stage: valid/ready handshake, branch squash
// FSM, flush handling and a saturating illegal-opcode counter.
module pic_decode_pipe
  import pic_decode_pipe_pkg::*;
#(
  parameter int unsigned PIC_INSTR_WIDTH = 12,
  parameter int unsigned PC_WIDTH        = 9,
  parameter int unsigned L2_NUM_FREG     = 5,
  parameter int unsigned DWIDTH          = 8,
  parameter int unsigned ILL_CNT_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst,
  pic_decode_pipe_if.slave bus
);

  if (PIC_INSTR_WIDTH != 12) begin : g_bad_instr_width
    $error("pic_decode_pipe: PIC_INSTR_WIDTH must be 12");
  end

  alu_op_e dec_op_c;
  logic    dec_branch_c, dec_call_c, dec_ret_c, dec_illegal_c;
  logic    accept_c;

  dec_state_e               state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  alu_op_e                  op_q, op_d;
  logic [L2_NUM_FREG-1:0]   freg_q, freg_d;
  logic [2:0]               bit_q, bit_d;
  logic                     dest_q, dest_d;
  logic [DWIDTH-1:0]        lit_q, lit_d;
  logic                     branch_q, branch_d, push_q, push_d, pop_q, pop_d;
  logic                     illegal_q, illegal_d;
  logic [PC_WIDTH-1:0]      baddr_q, baddr_d, paddr_q, paddr_d;
  logic [ILL_CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

  pic_decode_pipe_opcode_match u_match (
    .instr_i        (bus.instruction),
    .op_c_o         (dec_op_c),
    .is_branch_c_o  (dec_branch_c),
    .is_call_c_o    (dec_call_c),
    .is_ret_c_o     (dec_ret_c),
    .is_illegal_c_o (dec_illegal_c)
  );

  // Flush frees the slot so fetch never stalls behind an entry being killed.
  assign bus.in_ready = !out_valid_q || bus.out_ready || bus.flush;
  assign accept_c     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DEC_RUN;
      out_valid_q <= 1'b0;
      op_q        <= OP_NOP;
      freg_q      <= '0;
      bit_q       <= '0;
      dest_q      <= 1'b0;
      lit_q       <= '0;
      branch_q    <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      illegal_q   <= 1'b0;
      baddr_q     <= '0;
      paddr_q     <= '0;
      ill_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      freg_q      <= freg_d;
      bit_q       <= bit_d;
      dest_q      <= dest_d;
      lit_q       <= lit_d;
      branch_q    <= branch_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      illegal_q   <= illegal_d;
      baddr_q     <= baddr_d;
      paddr_q     <= paddr_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    freg_d      = freg_q;
    bit_d       = bit_q;
    dest_d      = dest_q;
    lit_d       = lit_q;
    branch_d    = branch_q;
    push_d      = push_q;
    pop_d       = pop_q;
    illegal_d   = illegal_q;
    baddr_d     = baddr_q;
    paddr_d     = paddr_q;
    ill_cnt_d   = ill_cnt_q;

    // Side-effect flags live only as long as the entry is presented.
    if (bus.flush || (out_valid_q && bus.out_ready)) begin
      out_valid_d = 1'b0;
      branch_d    = 1'b0;
      push_d      = 1'b0;
      pop_d       = 1'b0;
      illegal_d   = 1'b0;
    end

    if (bus.flush) begin
      state_d = DEC_RUN;
    end else if (accept_c && state_q == DEC_SQUASH) begin
      state_d = DEC_RUN;
    end else if (accept_c) begin
      out_valid_d = 1'b1;
      op_d        = dec_op_c;
      freg_d      = L2_NUM_FREG'(bus.instruction[4:0]);
      bit_d       = bus.instruction[7:5];
      dest_d      = bus.instruction[5];
      lit_d       = DWIDTH'(bus.instruction[7:0]);
      branch_d    = dec_branch_c;
      push_d      = dec_call_c;
      pop_d       = dec_ret_c;
      illegal_d   = dec_illegal_c;
      paddr_d     = bus.in_pc + PC_WIDTH'(1);
      if (dec_call_c) begin
        baddr_d = PC_WIDTH'(bus.instruction[7:0]);
      end else if (dec_branch_c && !dec_ret_c) begin
        baddr_d = PC_WIDTH'(bus.instruction[8:0]);
      end else begin
        baddr_d = '0;
      end
      if (dec_illegal_c && ill_cnt_q != '1) begin
        ill_cnt_d = ill_cnt_q + ILL_CNT_WIDTH'(1);
      end
      if (dec_branch_c) begin
        state_d = DEC_SQUASH;
      end
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.alu_instruction   = ALU_INST_WIDTH'(op_q);
  assign bus.alu_freg_num      = freg_q;
  assign bus.alu_bit_num       = bit_q;
  assign bus.alu_dest_bit      = dest_q;
  assign bus.alu_literal_value = lit_q;
  assign bus.branch_en         = branch_q;
  assign bus.branch_addr       = baddr_q;
  assign bus.push_en           = push_q;
  assign bus.push_addr         = paddr_q;
  assign bus.pop_en            = pop_q;
  assign bus.illegal           = illegal_q;
  assign bus.ill_count         = ill_cnt_q;

endmodule
